// File: rtl/multi_alarm_unit.sv
`timescale 1ns/1ps
// multi_alarm_unit: N-channel HH:MM alarm engine sharing one buzzer. Compares
// stored alarms on each minute tick, queues matches lowest-index first, and
// runs a ring/snooze session with a snooze limit and ring timeout.
module multi_alarm_unit #(
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 3,
  parameter int MAX_SNOOZE = 3,
  parameter int IDW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                min_tick,
  input  logic [15:0]         cur_time,
  input  logic                ld,
  input  logic [IDW-1:0]      ld_sel,
  input  logic [15:0]         ld_time,
  input  logic                ld_en,
  input  logic                stop,
  input  logic                snooze,
  output logic                buzz,
  output logic [IDW-1:0]      active_id,
  output logic                snoozing,
  output logic [N_ALARMS-1:0] pending,
  output logic [1:0]          dbg_state
);

  localparam int RW = $clog2(RING_MIN + 1);
  localparam int TW = $clog2(SNOOZE_MIN + 1);
  localparam int CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t              state;
  logic [15:0]         alarm_time [N_ALARMS];
  logic [N_ALARMS-1:0] alarm_en;
  logic [RW-1:0]       ring_cnt;
  logic [TW-1:0]       tmr;
  logic [CW-1:0]       snz_cnt;

  logic [N_ALARMS-1:0] match;
  logic [N_ALARMS-1:0] cand;
  logic [N_ALARMS-1:0] pend_nxt;
  logic [IDW-1:0]      win_id;
  logic                win_vld;
  logic                ld_hit;
  logic                kill_active;

  assign dbg_state = state;

  // Match compares against the stored value before any same-cycle ld lands.
  always_comb begin
    match       = '0;
    win_id      = '0;
    win_vld     = 1'b0;
    ld_hit      = ld && (int'(ld_sel) < N_ALARMS);
    kill_active = ld_hit && !ld_en && (state != IDLE) && (ld_sel == active_id);
    for (int i = 0; i < N_ALARMS; i++) begin
      if (min_tick && alarm_en[i] && (alarm_time[i] == cur_time) &&
          !((state != IDLE) && (active_id == IDW'(i))))
        match[i] = 1'b1;
    end
    cand = pending | match;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_id  = IDW'(i);
        win_vld = 1'b1;
      end
    end
    pend_nxt = cand;
    if (state == IDLE) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (win_vld && (win_id == IDW'(i)))
          pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      for (int i = 0; i < N_ALARMS; i++)
        alarm_time[i] <= '0;
      alarm_en  <= '0;
      pending   <= '0;
      state     <= IDLE;
      buzz      <= 1'b0;
      snoozing  <= 1'b0;
      active_id <= '0;
      ring_cnt  <= '0;
      tmr       <= '0;
      snz_cnt   <= '0;
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (ld_hit && (ld_sel == IDW'(i))) begin
          alarm_time[i] <= ld_time;
          alarm_en[i]   <= ld_en;
        end
      end
      pending <= pend_nxt;

      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= RING;
            buzz      <= 1'b1;
            snoozing  <= 1'b0;
            active_id <= win_id;
            ring_cnt  <= RW'(RING_MIN);
            snz_cnt   <= '0;
          end
        end
        RING: begin
          if (kill_active || stop) begin
            state    <= IDLE;
            buzz     <= 1'b0;
            snoozing <= 1'b0;
          end else if (snooze) begin
            // Once the snooze allowance is used up, snooze ends the session.
            if (int'(snz_cnt) < MAX_SNOOZE) begin
              state    <= SNOOZE;
              buzz     <= 1'b0;
              snoozing <= 1'b1;
              tmr      <= TW'(SNOOZE_MIN);
              snz_cnt  <= snz_cnt + 1'b1;
            end else begin
              state    <= IDLE;
              buzz     <= 1'b0;
              snoozing <= 1'b0;
            end
          end else if (min_tick) begin
            if (ring_cnt == RW'(1)) begin
              state    <= IDLE;
              buzz     <= 1'b0;
              snoozing <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt - 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (kill_active || stop) begin
            state    <= IDLE;
            buzz     <= 1'b0;
            snoozing <= 1'b0;
          end else if (min_tick) begin
            if (tmr == TW'(1)) begin
              state    <= RING;
              buzz     <= 1'b1;
              snoozing <= 1'b0;
              ring_cnt <= RW'(RING_MIN);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          buzz     <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multi_alarm_unit.md
# multi_alarm_unit

Parametrised N-channel alarm engine for the digital clock, successor to the single-alarm register/comparator/buzzer chain. It stores N independently enabled HH:MM alarm times, compares them against the running clock once per minute, and queues simultaneous matches. It drives one buzzer with snooze, a snooze limit and an automatic ring timeout. It sits beside the time counter and takes that block's BCD digits and minute tick.

## Interface
- N_ALARMS, 4: number of alarm channels (1..16)
- SNOOZE_MIN, 5: snooze length in minute ticks (≥1)
- RING_MIN, 3: minute ticks after which an unanswered ring auto-stops (≥1)
- MAX_SNOOZE, 3: snoozes allowed per ring session (0 disables snooze)
- IDW: derived, max(1, clog2(N_ALARMS))

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_  in  1  asynchronous, active-high reset (asserted = 1 despite the name)
- min_tick  in  1  one-cycle pulse when the clock advances a minute
- cur_time  in  16  current time {H1,H0,M1,M0} BCD, valid in the min_tick cycle
- ld  in  1  write strobe for one alarm channel
- ld_sel  in  IDW  channel written by ld
- ld_time  in  16  alarm time {H1,H0,M1,M0} BCD
- ld_en  in  1  enable bit written with ld_time
- stop  in  1  one-cycle stop request
- snooze  in  1  one-cycle snooze request
- buzz  out  1  buzzer drive, registered
- active_id  out  IDW  channel currently ringing/snoozing
- snoozing  out  1  high in SNOOZE state
- pending  out  N_ALARMS  channels matched but not yet serviced

## Operation
- Storage: per channel 16-bit time + enable. ld writes the selected channel at the clock edge. ld_sel ≥ N_ALARMS is ignored. There is no BCD validity check; the compare is bitwise equality.
- Match: in a min_tick cycle, channel i matches when enable[i] and alarm[i] == cur_time. A match sets pending[i]. A match for the channel currently ringing or snoozing is ignored.
- Arbitration: candidates = pending | match of this cycle. The lowest index wins.
- FSM states IDLE, RING, SNOOZE:
  - IDLE: if any candidate, go to RING with the winner's active_id. Clear its pending bit, load ring_cnt = RING_MIN and snz_cnt = 0.
  - RING: stop → IDLE.
  - RING: snooze with snz_cnt < MAX_SNOOZE → SNOOZE, with tmr = SNOOZE_MIN and snz_cnt+1.
  - RING: snooze with snz_cnt == MAX_SNOOZE → treated as stop.
  - RING: on min_tick, ring_cnt decrements. Reaching 0 → IDLE (auto-stop).
  - SNOOZE: on min_tick, tmr decrements. Reaching 0 → RING, ring_cnt = RING_MIN.
  - SNOOZE: stop → IDLE. Snooze is ignored.
- Disabling the active channel via ld (ld_en = 0) in RING or SNOOZE → IDLE next edge, session ended.
- Rewriting the time of the active channel with ld_en = 1 does not disturb the session.
- Simultaneous stop and snooze: stop wins. stop/snooze in IDLE: ignored.
- Simultaneous ld and match on the same channel: the match uses the old stored value.
- Reset: all alarm times 0, enables 0, pending 0, state IDLE, buzz 0, active_id 0, snoozing 0, counters 0.

## Timing
- buzz = (state == RING), registered. snoozing = (state == SNOOZE), registered.
- Match in min_tick cycle T with FSM idle: buzz = 1 from cycle T+1.
- pending[i] for a queued match is visible from T+1.
- stop/snooze sampled in cycle T: buzz = 0 from T+1.
- After leaving RING or SNOOZE the FSM spends at least one cycle in IDLE. The next pending channel rings from T+2.
- Auto-stop: buzz drops the cycle after the RING_MIN-th min_tick counted in RING. The min_tick of entry does not count.
- Snooze expiry: buzz returns the cycle after the SNOOZE_MIN-th min_tick in SNOOZE.
- Reset is asynchronous. Outputs go to reset values immediately, mid-session included.

## Test plan
- Load ch1 = 07:30 enabled; min_tick with cur_time 0x0730 → buzz = 1 and active_id = 1 next cycle; stop → buzz = 0 next cycle, pending = 0.
- ch0 and ch2 both 06:00; match → ch0 rings and pending = 4'b0100; stop → one idle cycle, then ch2 rings.
- Ring ch0; snooze → snoozing = 1; 5 min_ticks → buzz = 1 after the 5th. Repeat to a 4th snooze → treated as stop, state IDLE.
- Ring with no input → buzz falls after the 3rd min_tick. Stop and snooze in the same cycle → IDLE, no snooze.
- ld ch0 ld_en = 0 while ch0 snoozing → IDLE next edge. A matching time with ch0 disabled never sets pending.
- Assert reset_ mid-RING with pending bits set → buzz, pending, snoozing and active_id all 0 asynchronously; stored alarms cleared.
